// File: rtl/round_judge.sv
// -----------------------------------------------------------------------------
// round_judge
//   Game-round controller feeding the scoreboard display stage. Each round a
//   nonzero 4-bit finger pattern is drawn from a free-running LFSR, the player
//   is given a bounded response window, and the debounced buttons are judged
//   as hit or miss. Score accumulates over a fixed number of rounds, then a
//   pass/fail verdict is shown until the next start press.
//
// Ports
//   clk      in   1  machine clock
//   rst      in   1  synchronous reset, active low
//   btn      in   4  debounced finger buttons, level, 1 = pressed
//   start    in   1  debounced start button, level (rising edge detected here)
//   score    out  8  hits this game, binary, saturating at 255
//   pattern  out  4  target pattern, 0 when no round is active
//   C        out  1  1 = playing/idle (show score), 0 = game over (show verdict)
//   res      out  1  verdict when C = 0: 1 = pass, 0 = fail; 0 whenever C = 1
//   busy     out  1  1 while between rounds (GAP) or in a round (PLAY)
// -----------------------------------------------------------------------------
module round_judge #(
    parameter int unsigned WINDOW     = 50_000_000,
    parameter int unsigned GAP        = 12_500_000,
    parameter int unsigned ROUNDS     = 20,
    parameter int unsigned PASS_SCORE = 15,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       start,
    output logic [7:0] score,
    output logic [3:0] pattern,
    output logic       C,
    output logic       res,
    output logic       busy
);

    // One timer serves both the gap and the response window, so it is sized
    // for the longer of the two.
    localparam int unsigned TMAX = (WINDOW > GAP) ? WINDOW : GAP;
    localparam int          TW   = $clog2(TMAX);

    localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [7:0]    ROUNDS_L = 8'(ROUNDS);
    // Nine bits so a threshold of 256 (never reachable) still compares sanely.
    localparam logic [8:0]    PASS_L   = (PASS_SCORE > 256) ? 9'd256 : 9'(PASS_SCORE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_PLAY,
        S_DONE
    } state_e;

    state_e        state_q;
    logic [7:0]    lfsr_q;
    logic [7:0]    lfsr_d;
    logic          start_q;
    logic [TW-1:0] timer_q;
    logic [7:0]    round_q;
    logic [7:0]    score_q;
    logic [3:0]    pattern_q;
    logic          c_q;
    logic          res_q;
    logic          busy_q;

    logic          start_rise;
    logic [3:0]    draw_pat;
    logic          hit;
    logic          wrong;
    logic          timeout;
    logic [7:0]    score_d;

    // Fibonacci LFSR, taps 8,6,5,4: maximal length, never reaches zero.
    assign lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign start_rise = start & ~start_q;

    // A zero low nibble would be an impossible target, so it maps to one finger.
    assign draw_pat = (lfsr_q[3:0] == 4'd0) ? 4'b0001 : lfsr_q[3:0];

    // Judgement priority inside a round: hit, then wrong button, then timeout.
    // A partial subset press is neither, so the round keeps waiting.
    assign hit     = (btn == pattern_q);
    assign wrong   = ~hit && ((btn & ~pattern_q) != 4'd0);
    assign timeout = ~hit && ~wrong && (timer_q == WIN_LAST);

    // Score after a judged round; saturates rather than wrapping.
    assign score_d = (hit && score_q != 8'hFF) ? score_q + 8'd1 : score_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            // Starting high means a start button held through reset does not
            // look like a fresh press.
            start_q   <= 1'b1;
            timer_q   <= '0;
            round_q   <= 8'd0;
            score_q   <= 8'd0;
            pattern_q <= 4'd0;
            c_q       <= 1'b1;
            res_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= start;

            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        state_q <= S_GAP;
                        score_q <= 8'd0;
                        round_q <= 8'd0;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_GAP: begin
                    // Any held button restarts the idle gap, so the next round
                    // only opens after GAP consecutive released cycles.
                    if (btn != 4'd0) begin
                        timer_q <= '0;
                    end else if (timer_q == GAP_LAST) begin
                        state_q   <= S_PLAY;
                        pattern_q <= draw_pat;
                        round_q   <= round_q + 8'd1;
                        timer_q   <= '0;
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end

                S_PLAY: begin
                    if (hit || wrong || timeout) begin
                        score_q   <= score_d;
                        pattern_q <= 4'd0;
                        timer_q   <= '0;
                        if (round_q == ROUNDS_L) begin
                            state_q <= S_DONE;
                            c_q     <= 1'b0;
                            res_q   <= ({1'b0, score_d} >= PASS_L);
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_GAP;
                        end
                    end else begin
                        timer_q <= timer_q + T_ONE;
                    end
                end

                S_DONE: begin
                    if (start_rise) begin
                        state_q <= S_GAP;
                        score_q <= 8'd0;
                        res_q   <= 1'b0;
                        c_q     <= 1'b1;
                        round_q <= 8'd0;
                        timer_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign score   = score_q;
    assign pattern = pattern_q;
    assign C       = c_q;
    assign res     = res_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_round_judge.sv
// -----------------------------------------------------------------------------
// tb_round_judge
//   Self-checking bench for round_judge with a small game (WINDOW=8, GAP=4,
//   ROUNDS=3, PASS_SCORE=2). Inputs change and outputs are sampled on the
//   falling clock edge. Expected values come from a game-level model: the
//   LFSR sequence from its seed, a hit counter, a round counter, and the
//   timing rules of gap and response window.
// -----------------------------------------------------------------------------
module tb_round_judge;

    localparam int         WINDOW     = 8;
    localparam int         GAP        = 4;
    localparam int         ROUNDS     = 3;
    localparam int         PASS_SCORE = 2;
    localparam logic [7:0] SEED       = 8'hA5;

    typedef enum int {K_HIT, K_TIMEOUT, K_WRONG, K_SUBSET} kind_e;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] btn   = 4'd0;
    logic       start = 1'b0;
    logic [7:0] score;
    logic [3:0] pattern;
    logic       C;
    logic       res;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Game-level model state.
    logic [7:0] m_lfsr;
    int         exp_score;
    int         exp_round;
    logic [3:0] cur_pat;
    logic       in_done;

    logic [14:0] obs;
    logic [14:0] want;

    round_judge #(
        .WINDOW    (WINDOW),
        .GAP       (GAP),
        .ROUNDS    (ROUNDS),
        .PASS_SCORE(PASS_SCORE),
        .LFSR_SEED (SEED)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .start  (start),
        .score  (score),
        .pattern(pattern),
        .C      (C),
        .res    (res),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    assign obs = {score, pattern, C, res, busy};

    // Reference LFSR sequence: seed on reset, one step per clock otherwise.
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [14:0] pack(int s, logic [3:0] p, logic c, logic r, logic b);
        return {8'(s), p, c, r, b};
    endfunction

    function automatic string fmt(logic [14:0] v);
        return $sformatf("score=%0d pattern=%h C=%b res=%b busy=%b",
                         v[14:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    function automatic logic [3:0] draw(logic [7:0] l);
        return (l[3:0] == 4'd0) ? 4'b0001 : l[3:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start a game from IDLE or DONE with a clean rising edge on start.
    task automatic start_game();
        start = 1'b0;
        tick();
        want = in_done ? pack(exp_score, 4'd0, 1'b0, (exp_score >= PASS_SCORE), 1'b0)
                       : pack(0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL pre_start: got %s, want %s", fmt(obs), fmt(want));
        end
        start = 1'b1;
        tick();
        exp_score = 0;
        exp_round = 0;
        in_done   = 1'b0;
        want = pack(0, 4'd0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL start_game: got %s, want %s", fmt(obs), fmt(want));
        end
        start = 1'b0;
    endtask

    // From the first GAP cycle: hold random buttons for 'hold' cycles, then
    // release; the round opens on exactly the GAP-th released edge.
    task automatic gap_to_play(int hold);
        for (int i = 0; i < hold; i++) begin
            btn = 4'($urandom_range(1, 15));
            tick();
            want = pack(exp_score, 4'd0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL gap_hold: got %s, want %s", fmt(obs), fmt(want));
            end
        end
        btn = 4'd0;
        for (int i = 0; i < GAP - 1; i++) begin
            tick();
            want = pack(exp_score, 4'd0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL gap_count: got %s, want %s", fmt(obs), fmt(want));
            end
        end
        cur_pat = draw(m_lfsr);
        tick();
        exp_round++;
        want = pack(exp_score, cur_pat, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL play_entry: got %s, want %s", fmt(obs), fmt(want));
        end
    endtask

    // One round from the first PLAY cycle: d idle cycles, then the chosen
    // response. Subset presses last s cycles before the full pattern.
    task automatic play(kind_e kind_in, int d, int s);
        kind_e      kind;
        logic [3:0] extra;
        logic [3:0] sub;
        logic [3:0] press;
        bit         is_hit;
        kind  = kind_in;
        sub   = cur_pat & (~cur_pat + 4'd1);
        extra = 4'd0;
        if (kind == K_WRONG && cur_pat == 4'hF) kind = K_HIT;
        if (kind == K_SUBSET && sub == cur_pat) kind = K_HIT;
        if (kind == K_WRONG) begin
            while ((extra & ~cur_pat) == 4'd0) extra = 4'd1 << $urandom_range(0, 3);
        end
        for (int i = 0; i < d; i++) begin
            tick();
            want = pack(exp_score, cur_pat, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL play_wait: got %s, want %s", fmt(obs), fmt(want));
            end
        end
        press  = 4'd0;
        is_hit = 1'b0;
        case (kind)
            K_HIT: begin
                press  = cur_pat;
                is_hit = 1'b1;
            end
            K_WRONG: press = (cur_pat & 4'($urandom())) | extra;
            K_SUBSET: begin
                btn = sub;
                for (int i = 0; i < s; i++) begin
                    tick();
                    want = pack(exp_score, cur_pat, 1'b1, 1'b0, 1'b1);
                    checks++;
                    if (obs !== want) begin
                        errors++;
                        $display("FAIL play_subset: got %s, want %s", fmt(obs), fmt(want));
                    end
                end
                press  = cur_pat;
                is_hit = 1'b1;
            end
            default: press = 4'd0;
        endcase
        btn = press;
        tick();
        if (is_hit && exp_score < 255) exp_score++;
        if (exp_round == ROUNDS) begin
            in_done = 1'b1;
            want = pack(exp_score, 4'd0, 1'b0, (exp_score >= PASS_SCORE), 1'b0);
        end else begin
            want = pack(exp_score, 4'd0, 1'b1, 1'b0, 1'b1);
        end
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL round_end(kind=%0d d=%0d): got %s, want %s",
                     int'(kind), d, fmt(obs), fmt(want));
        end
        btn = 4'd0;
    endtask

    task automatic play_random();
        int k;
        int d;
        k = $urandom_range(0, 3);
        case (k)
            0: play(K_HIT, $urandom_range(0, WINDOW - 1), 0);
            1: play(K_TIMEOUT, WINDOW - 1, 0);
            2: play(K_WRONG, $urandom_range(0, WINDOW - 1), 0);
            default: begin
                d = $urandom_range(0, WINDOW - 3);
                play(K_SUBSET, d, $urandom_range(1, WINDOW - 1 - d));
            end
        endcase
    endtask

    task automatic test_reset();
        start = 1'b1;
        rst   = 1'b0;
        tick();
        tick();
        exp_score = 0;
        exp_round = 0;
        in_done   = 1'b0;
        want = pack(0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL reset_values: got %s, want %s", fmt(obs), fmt(want));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL held_start_idle: got %s, want %s", fmt(obs), fmt(want));
            end
        end
        start_game();
    endtask

    task automatic test_all_hits();
        for (int r = 0; r < ROUNDS; r++) begin
            gap_to_play(0);
            play(K_HIT, 2, 0);
        end
    endtask

    task automatic test_timeouts();
        start_game();
        for (int r = 0; r < ROUNDS; r++) begin
            gap_to_play(0);
            play(K_TIMEOUT, WINDOW - 1, 0);
        end
    endtask

    task automatic test_wrong_subset();
        start_game();
        gap_to_play(0);
        play(K_WRONG, $urandom_range(0, WINDOW - 1), 0);
        gap_to_play(0);
        play(K_SUBSET, 1, 3);
        gap_to_play(0);
        play(K_WRONG, 0, 0);
    endtask

    task automatic test_gap_hold_late_hit();
        start_game();
        gap_to_play(5);
        play(K_HIT, WINDOW - 1, 0);
        gap_to_play($urandom_range(1, 6));
        play(K_SUBSET, WINDOW - 2, 1);
        gap_to_play(2);
        play(K_HIT, $urandom_range(0, WINDOW - 1), 0);
    endtask

    task automatic test_reset_mid_play();
        start_game();
        gap_to_play(0);
        play(K_HIT, 1, 0);
        gap_to_play(0);
        for (int i = 0; i < 3; i++) begin
            tick();
            want = pack(exp_score, cur_pat, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== want) begin
                errors++;
                $display("FAIL mid_play_wait: got %s, want %s", fmt(obs), fmt(want));
            end
        end
        rst = 1'b0;
        tick();
        exp_score = 0;
        exp_round = 0;
        in_done   = 1'b0;
        want = pack(0, 4'd0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL mid_play_reset: got %s, want %s", fmt(obs), fmt(want));
        end
        rst = 1'b1;
        start_game();
        for (int r = 0; r < ROUNDS; r++) begin
            gap_to_play($urandom_range(0, 2));
            play_random();
        end
        // Restart from DONE must clear score and verdict.
        start_game();
        for (int r = 0; r < ROUNDS; r++) begin
            gap_to_play(0);
            play(K_HIT, $urandom_range(0, WINDOW - 1), 0);
        end
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 4; g++) begin
            start_game();
            for (int r = 0; r < ROUNDS; r++) begin
                gap_to_play($urandom_range(0, 3));
                play_random();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_all_hits();
        test_timeouts();
        test_wrong_subset();
        test_gap_hold_late_hit();
        test_reset_mid_play();
        test_random_games();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
